uart_tx_cfg: RTL and testbench

Parametrised UART transmitter and successor to the fixed 8N1 transmitter. Data width, parity mode and stop-bit count are compile-time parameters. Input uses a valid/ready handshake with a one-entry holding register, so frames can run back-to-back with no idle gap. It sits between the byte-producing logic and the serial TX pin, one instance per channel.

---
 rtl/uart_tx_cfg.sv | 157 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with a one-entry holding register.
// Data width, parity mode and stop-bit count are fixed at elaboration.
module uart_tx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 2000000,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Tx_Valid,
  input  logic [DATA_BITS-1:0] Tx_Data,
  output logic                 Tx_Ready,
  output logic                 Tx_Serial,
  output logic                 Tx_Active,
  output logic                 Tx_Done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam logic [31:0] CNT_LAST = 32'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  DB_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]  SB_LAST  = 4'(STOP_BITS - 1);
  localparam logic        HAS_PAR  = (PARITY != 0);
  localparam logic        ODD_PAR  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] hold_q;
  logic                 par_q, par_d;
  logic                 hold_full_q, hold_full_d;
  logic                 accept, xfer;
  logic                 bit_end;
  logic                 ser_d, done_d;

  assign accept  = Tx_Valid & Tx_Ready;
  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    xfer    = 1'b0;
    done_d  = 1'b0;
    ser_d   = 1'b1;
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? 32'd0 : cnt_q + 32'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          xfer    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        ser_d = 1'b0;
        if (bit_end) begin
          idx_d   = 4'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        ser_d = sh_q[0];
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (idx_q == DB_LAST) begin
            idx_d   = 4'd0;
            state_d = HAS_PAR ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        ser_d = par_q;
        if (bit_end) begin
          idx_d   = 4'd0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == SB_LAST) begin
            done_d  = 1'b1;
            idx_d   = 4'd0;
            xfer    = hold_full_q;
            state_d = hold_full_q ? S_START : S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Parity is frozen from the word as it enters the shifter.
    if (xfer) begin
      sh_d  = hold_q;
      par_d = (^hold_q) ^ ODD_PAR;
      cnt_d = 32'd0;
      idx_d = 4'd0;
    end
    hold_full_d = xfer ? 1'b0 : (accept | hold_full_q);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      par_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      Tx_Ready    <= 1'b0;
      Tx_Serial   <= 1'b1;
      Tx_Active   <= 1'b0;
      Tx_Done     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      par_q       <= par_d;
      if (accept) hold_q <= Tx_Data;
      hold_full_q <= hold_full_d;
      Tx_Ready    <= ~hold_full_d;
      Tx_Serial   <= ser_d;
      Tx_Active   <= (state_q != S_IDLE);
      Tx_Done     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five configurations checked cycle by cycle
// against a frame model built from word, parity and timing rules.
module tb_uart_tx_cfg;

  localparam int NI = 5;
  localparam int CPB [NI] = '{4, 4, 4, 4, 2};
  localparam int DB  [NI] = '{8, 8, 8, 5, 8};
  localparam int PAR [NI] = '{0, 1, 2, 0, 0};
  localparam int SB  [NI] = '{1, 1, 1, 2, 1};

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [NI-1:0] valid = '0;
  logic [8:0]    data [NI];
  wire  [NI-1:0] rdy, ser, act, done;

  int total = 0;
  int pass  = 0;

  logic ser_r  [256];
  logic act_r  [256];
  logic done_r [256];
  logic rdy_r  [256];
  int   acc_c  [4];
  int   nacc;

  always #5 Clk = ~Clk;

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .Clk(Clk), .Rst(Rst), .Tx_Valid(valid[0]), .Tx_Data(data[0][7:0]),
    .Tx_Ready(rdy[0]), .Tx_Serial(ser[0]), .Tx_Active(act[0]), .Tx_Done(done[0]));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .Clk(Clk), .Rst(Rst), .Tx_Valid(valid[1]), .Tx_Data(data[1][7:0]),
    .Tx_Ready(rdy[1]), .Tx_Serial(ser[1]), .Tx_Active(act[1]), .Tx_Done(done[1]));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .Clk(Clk), .Rst(Rst), .Tx_Valid(valid[2]), .Tx_Data(data[2][7:0]),
    .Tx_Ready(rdy[2]), .Tx_Serial(ser[2]), .Tx_Active(act[2]), .Tx_Done(done[2]));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u3 (
    .Clk(Clk), .Rst(Rst), .Tx_Valid(valid[3]), .Tx_Data(data[3][4:0]),
    .Tx_Ready(rdy[3]), .Tx_Serial(ser[3]), .Tx_Active(act[3]), .Tx_Done(done[3]));
  uart_tx_cfg #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u4 (
    .Clk(Clk), .Rst(Rst), .Tx_Valid(valid[4]), .Tx_Data(data[4][7:0]),
    .Tx_Ready(rdy[4]), .Tx_Serial(ser[4]), .Tx_Active(act[4]), .Tx_Done(done[4]));

  function automatic int flen(input int k);
    return CPB[k] * (1 + DB[k] + ((PAR[k] != 0) ? 1 : 0) + SB[k]);
  endfunction

  // Expected {serial, active, done} at cycle c for nw frames from cycle s.
  function automatic logic [2:0] model(input int k, input int c, input int s,
                                       input logic [8:0] w [4], input int nw,
                                       input int cut);
    int L, f, off, b, ones;
    logic [8:0] wd;
    logic sv;
    L = flen(k);
    if (c < s || c >= s + nw * L || c >= cut) return 3'b100;
    f   = (c - s) / L;
    off = (c - s) % L;
    b   = off / CPB[k];
    wd  = w[f] & 9'((1 << DB[k]) - 1);
    ones = $countones(wd);
    if (b == 0) sv = 1'b0;
    else if (b <= DB[k]) sv = wd[b-1];
    else if (PAR[k] != 0 && b == DB[k] + 1)
      sv = (PAR[k] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    else sv = 1'b1;
    return {sv, 1'b1, (off == L - 1)};
  endfunction

  // Drives words on instance k with valid held and records outputs per cycle.
  task automatic run(input int k, input logic [8:0] w [4], input int nw,
                     input int ncyc, input int rst_at);
    int idx;
    bit pend;
    idx = 0;
    pend = 0;
    nacc = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge Clk);
      Rst = (c == rst_at);
      if (c == 0) begin
        valid[k] = (nw > 0);
        data[k]  = w[0];
      end
      if (pend) begin
        idx++;
        pend = 0;
        if (idx < nw) data[k] = w[idx];
        else valid[k] = 1'b0;
      end
      ser_r[c]  = ser[k];
      act_r[c]  = act[k];
      done_r[c] = done[k];
      rdy_r[c]  = rdy[k];
      if (valid[k] && rdy[k] && !Rst) begin
        pend = 1;
        if (nacc < 4) acc_c[nacc] = c;
        nacc++;
      end
    end
    valid[k] = 1'b0;
    Rst = 1'b0;
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    valid = '0;
    for (int i = 0; i < NI; i++) data[i] = '0;
    repeat (3) @(negedge Clk);
    total++;
    if (ser !== 5'h1f) $display("FAIL reset_ser got=%b exp=%b", ser, 5'h1f);
    else pass++;
    total++;
    if (act !== 5'h00) $display("FAIL reset_act got=%b exp=%b", act, 5'h00);
    else pass++;
    total++;
    if (done !== 5'h00) $display("FAIL reset_done got=%b exp=%b", done, 5'h00);
    else pass++;
    total++;
    if (rdy !== 5'h00) $display("FAIL reset_rdy got=%b exp=%b", rdy, 5'h00);
    else pass++;
    Rst = 1'b0;
    @(negedge Clk);
    total++;
    if (rdy !== 5'h1f) $display("FAIL rdy_after_reset got=%b exp=%b", rdy, 5'h1f);
    else pass++;
  endtask

  task automatic test_8n1;
    logic [8:0] w [4];
    logic [2:0] obs, ex;
    int s, n, na, nd;
    w = '{9'h0A5, 9'h0, 9'h0, 9'h0};
    n = 4 + 40 + 6;
    run(0, w, 1, n, -1);
    total++;
    if (nacc != 1 || acc_c[0] != 0)
      $display("FAIL 8n1_accept got=%0d@%0d exp=1@0", nacc, acc_c[0]);
    else pass++;
    s = acc_c[0] + 3;
    na = 0;
    nd = 0;
    for (int c = 0; c < n; c++) begin
      obs = {ser_r[c], act_r[c], done_r[c]};
      ex  = model(0, c, s, w, 1, 1 << 30);
      na += int'(act_r[c]);
      nd += int'(done_r[c]);
      total++;
      if (obs !== ex) $display("FAIL 8n1_line cyc=%0d got=%b exp=%b", c, obs, ex);
      else pass++;
    end
    total++;
    if (na != 40) $display("FAIL 8n1_active_len got=%0d exp=40", na);
    else pass++;
    total++;
    if (nd != 1 || done_r[s+39] !== 1'b1)
      $display("FAIL 8n1_done got=%0d pulses exp=1 at %0d", nd, s + 39);
    else pass++;
  endtask

  task automatic test_parity;
    logic [8:0] w [4];
    logic [2:0] obs, ex;
    int s, n, na;
    w = '{9'h007, 9'h0, 9'h0, 9'h0};
    for (int k = 1; k <= 2; k++) begin
      n = 4 + 44 + 6;
      run(k, w, 1, n, -1);
      s = acc_c[0] + 3;
      na = 0;
      for (int c = 0; c < n; c++) begin
        obs = {ser_r[c], act_r[c], done_r[c]};
        ex  = model(k, c, s, w, 1, 1 << 30);
        na += int'(act_r[c]);
        total++;
        if (obs !== ex) $display("FAIL parity%0d_line cyc=%0d got=%b exp=%b", k, c, obs, ex);
        else pass++;
      end
      total++;
      if (ser_r[s+36] !== ((k == 1) ? 1'b0 : 1'b1))
        $display("FAIL parity%0d_bit got=%b exp=%b", k, ser_r[s+36], (k == 2));
      else pass++;
      total++;
      if (na != 44) $display("FAIL parity%0d_len got=%0d exp=44", k, na);
      else pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] w [4];
    logic [2:0] obs, ex;
    int s, n, na, nd, d0, d1;
    w = '{9'h03C, 9'h0C3, 9'h0, 9'h0};
    n = 4 + 80 + 6;
    run(0, w, 2, n, -1);
    s = acc_c[0] + 3;
    total++;
    if (nacc != 2 || acc_c[1] > s + 40 - 3)
      $display("FAIL b2b_accept got=%0d@%0d exp=2 before %0d", nacc, acc_c[1], s + 37);
    else pass++;
    na = 0;
    nd = 0;
    d0 = -1;
    d1 = -1;
    for (int c = 0; c < n; c++) begin
      obs = {ser_r[c], act_r[c], done_r[c]};
      ex  = model(0, c, s, w, 2, 1 << 30);
      na += int'(act_r[c]);
      if (done_r[c]) begin
        if (nd == 0) d0 = c;
        else d1 = c;
        nd++;
      end
      total++;
      if (obs !== ex) $display("FAIL b2b_line cyc=%0d got=%b exp=%b", c, obs, ex);
      else pass++;
    end
    total++;
    if (na != 80) $display("FAIL b2b_active got=%0d exp=80", na);
    else pass++;
    total++;
    if (nd != 2 || d1 - d0 != 40)
      $display("FAIL b2b_done got=%0d pulses gap=%0d exp=2 gap=40", nd, d1 - d0);
    else pass++;
  endtask

  task automatic test_5bit_2stop;
    logic [8:0] w [4];
    logic [2:0] obs, ex;
    int a, s, n, na;
    w = '{9'h01F, 9'h0, 9'h0, 9'h0};
    n = 4 + flen(3) + 6;
    run(3, w, 1, n, -1);
    a = acc_c[0];
    s = a + 3;
    total++;
    if (rdy_r[a] !== 1'b1 || rdy_r[a+1] !== 1'b0 || rdy_r[a+2] !== 1'b1)
      $display("FAIL 5b_ready got=%b%b%b exp=101", rdy_r[a], rdy_r[a+1], rdy_r[a+2]);
    else pass++;
    na = 0;
    for (int c = 0; c < n; c++) begin
      obs = {ser_r[c], act_r[c], done_r[c]};
      ex  = model(3, c, s, w, 1, 1 << 30);
      na += int'(act_r[c]);
      total++;
      if (obs !== ex) $display("FAIL 5b_line cyc=%0d got=%b exp=%b", c, obs, ex);
      else pass++;
    end
    total++;
    if (na != 32) $display("FAIL 5b_len got=%0d exp=32", na);
    else pass++;
  endtask

  task automatic test_mid_reset;
    logic [8:0] w [4];
    logic [2:0] obs, ex;
    int s, n, nd, ra;
    w = '{9'($urandom_range(0, 255)), 9'h0, 9'h0, 9'h0};
    ra = 3 + 16 + 1;
    n = 40;
    run(0, w, 1, n, ra);
    total++;
    if (acc_c[0] != 0) $display("FAIL rst_accept got=%0d exp=0", acc_c[0]);
    else pass++;
    s = acc_c[0] + 3;
    nd = 0;
    for (int c = 0; c < n; c++) begin
      obs = {ser_r[c], act_r[c], done_r[c]};
      ex  = model(0, c, s, w, 1, ra + 1);
      nd += int'(done_r[c]);
      total++;
      if (obs !== ex) $display("FAIL rst_line cyc=%0d got=%b exp=%b", c, obs, ex);
      else pass++;
    end
    total++;
    if (nd != 0) $display("FAIL rst_no_done got=%0d exp=0", nd);
    else pass++;
    total++;
    if (rdy_r[ra+1] !== 1'b0 || rdy_r[ra+2] !== 1'b1)
      $display("FAIL rst_ready got=%b%b exp=01", rdy_r[ra+1], rdy_r[ra+2]);
    else pass++;
    w = '{9'h055, 9'h0, 9'h0, 9'h0};
    n = 4 + 40 + 6;
    run(0, w, 1, n, -1);
    s = acc_c[0] + 3;
    for (int c = 0; c < n; c++) begin
      obs = {ser_r[c], act_r[c], done_r[c]};
      ex  = model(0, c, s, w, 1, 1 << 30);
      total++;
      if (obs !== ex) $display("FAIL rst_after_line cyc=%0d got=%b exp=%b", c, obs, ex);
      else pass++;
    end
  endtask

  task automatic test_min_cpb;
    logic [8:0] w [4];
    logic [2:0] obs, ex;
    int s, n, nd, dp, gap_bad;
    w = '{9'h0FF, 9'h0FF, 9'h0FF, 9'h0};
    n = 4 + 60 + 6;
    run(4, w, 3, n, -1);
    s = acc_c[0] + 3;
    nd = 0;
    dp = -1;
    gap_bad = 0;
    for (int c = 0; c < n; c++) begin
      obs = {ser_r[c], act_r[c], done_r[c]};
      ex  = model(4, c, s, w, 3, 1 << 30);
      if (done_r[c]) begin
        if (dp >= 0 && c - dp != 20) gap_bad++;
        dp = c;
        nd++;
      end
      total++;
      if (obs !== ex) $display("FAIL cpb2_line cyc=%0d got=%b exp=%b", c, obs, ex);
      else pass++;
    end
    total++;
    if (nd != 3 || gap_bad != 0)
      $display("FAIL cpb2_done got=%0d pulses bad_gaps=%0d exp=3 gaps=20", nd, gap_bad);
    else pass++;
  endtask

  task automatic test_random;
    logic [8:0] w [4];
    logic [2:0] obs, ex;
    int s, n, nw, errs;
    for (int k = 0; k < NI; k++) begin
      for (int it = 0; it < 2; it++) begin
        nw = $urandom_range(1, 3);
        for (int i = 0; i < 4; i++) w[i] = 9'($urandom_range(0, 511));
        n = 4 + nw * flen(k) + 6;
        run(k, w, nw, n, -1);
        s = acc_c[0] + 3;
        errs = 0;
        total++;
        if (nacc != nw) $display("FAIL rand%0d_accepts got=%0d exp=%0d", k, nacc, nw);
        else pass++;
        for (int c = 0; c < n; c++) begin
          obs = {ser_r[c], act_r[c], done_r[c]};
          ex  = model(k, c, s, w, nw, 1 << 30);
          total++;
          if (obs !== ex) begin
            errs++;
            $display("FAIL rand%0d_line cyc=%0d got=%b exp=%b", k, c, obs, ex);
          end else pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_5bit_2stop();
    test_mid_reset();
    test_min_cpb();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
